// File: rtl/gpio_port_ctrl.sv
// GPIO bank controller: direction and output registers with atomic set/clear/toggle,
// synchronised inputs, and per-pin edge interrupts with write-one-to-clear status.
module gpio_port_ctrl #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    input  logic [3:0]       addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             rd_valid_o,
    input  logic [WIDTH-1:0] gpio_in_i,
    output logic [WIDTH-1:0] gpio_out_o,
    output logic [WIDTH-1:0] gpio_dir_o,
    output logic             irq_o
);

    localparam logic [3:0] ADDR_DIR     = 4'd0;
    localparam logic [3:0] ADDR_OUT     = 4'd1;
    localparam logic [3:0] ADDR_OUT_SET = 4'd2;
    localparam logic [3:0] ADDR_OUT_CLR = 4'd3;
    localparam logic [3:0] ADDR_OUT_TGL = 4'd4;
    localparam logic [3:0] ADDR_IN      = 4'd5;
    localparam logic [3:0] ADDR_RISE_EN = 4'd6;
    localparam logic [3:0] ADDR_FALL_EN = 4'd7;
    localparam logic [3:0] ADDR_STATUS  = 4'd8;

    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rd_valid_q;
    logic             irq_q;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prev_q;

    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] status_set;
    logic [WIDTH-1:0] status_clr;
    logic [WIDTH-1:0] rd_mux;

    // Stage 0 takes the raw pad; the last stage is the metastability-safe value.
    assign sync_in = sync_q[SYNC_STAGES-1];
    assign rise    = sync_in & ~prev_q;
    assign fall    = ~sync_in & prev_q;

    assign status_set = ~dir_q & ((rise & rise_en_q) | (fall & fall_en_q));

    always_comb begin
        dir_d      = dir_q;
        out_d      = out_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        status_clr = '0;
        if (wr_en_i) begin
            case (addr_i)
                ADDR_DIR:     dir_d      = wdata_i;
                ADDR_OUT:     out_d      = wdata_i;
                ADDR_OUT_SET: out_d      = out_q | wdata_i;
                ADDR_OUT_CLR: out_d      = out_q & ~wdata_i;
                ADDR_OUT_TGL: out_d      = out_q ^ wdata_i;
                ADDR_RISE_EN: rise_en_d  = wdata_i;
                ADDR_FALL_EN: fall_en_d  = wdata_i;
                ADDR_STATUS:  status_clr = wdata_i;
                default:      ;
            endcase
        end
        // A new edge in the same cycle as a clear keeps the bit set.
        status_d = (status_q & ~status_clr) | status_set;
    end

    always_comb begin
        rd_mux = '0;
        case (addr_i)
            ADDR_DIR:     rd_mux = dir_q;
            ADDR_OUT:     rd_mux = out_q;
            ADDR_IN:      rd_mux = sync_in;
            ADDR_RISE_EN: rd_mux = rise_en_q;
            ADDR_FALL_EN: rd_mux = fall_en_q;
            ADDR_STATUS:  rd_mux = status_q;
            default:      rd_mux = '0;
        endcase
        rdata_d = rd_en_i ? rd_mux : rdata_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dir_q      <= '0;
            out_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            status_q   <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
            sync_q     <= '0;
            prev_q     <= '0;
        end else begin
            dir_q      <= dir_d;
            out_q      <= out_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            status_q   <= status_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_en_i;
            irq_q      <= |status_q;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], gpio_in_i};
            prev_q     <= sync_in;
        end
    end

    assign rdata_o    = rdata_q;
    assign rd_valid_o = rd_valid_q;
    assign gpio_out_o = out_q;
    assign gpio_dir_o = dir_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Randomised and directed bench for gpio_port_ctrl, checked every cycle against
// a register-map model that tracks pad history as a plain sample array.
module tb_gpio_port_ctrl;

    localparam int W = 16;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [3:0]   addr = '0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] gin = '0;
    logic [W-1:0] rdata;
    logic         rd_valid;
    logic [W-1:0] gpio_out;
    logic [W-1:0] gpio_dir;
    logic         irq;

    int assertCount = 0;
    int failCount = 0;
    bit cmpEn = 1'b0;

    gpio_port_ctrl #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wr_en_i    (wr_en),
        .rd_en_i    (rd_en),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .rdata_o    (rdata),
        .rd_valid_o (rd_valid),
        .gpio_in_i  (gin),
        .gpio_out_o (gpio_out),
        .gpio_dir_o (gpio_dir),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    // Reference model state; hist[k] is the pad value sampled k edges ago.
    logic [W-1:0] mDir, mOut, mRise, mFall, mStat, mRdata;
    logic         mRdv, mIrq;
    logic [W-1:0] hist [S+1];
    logic [W-1:0] mSync, mPrev, mSet, mClr;

    function automatic logic [W-1:0] readModel(input logic [3:0] a);
        case (a)
            4'd0:    return mDir;
            4'd1:    return mOut;
            4'd5:    return hist[S-1];
            4'd6:    return mRise;
            4'd7:    return mFall;
            4'd8:    return mStat;
            default: return '0;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mDir = '0; mOut = '0; mRise = '0; mFall = '0; mStat = '0;
                mRdata = '0; mRdv = 1'b0; mIrq = 1'b0;
                for (int i = 0; i <= S; i++) hist[i] = '0;
            end else begin
                mSync = hist[S-1];
                mPrev = hist[S];
                mSet  = ~mDir & ((mSync & ~mPrev & mRise) | (~mSync & mPrev & mFall));
                mClr  = (wr_en && addr == 4'd8) ? wdata : '0;
                mIrq  = (mStat != '0);
                mRdv  = rd_en;
                if (rd_en) mRdata = readModel(addr);
                if (wr_en) begin
                    case (addr)
                        4'd0: mDir  = wdata;
                        4'd1: mOut  = wdata;
                        4'd2: mOut  = mOut | wdata;
                        4'd3: mOut  = mOut & ~wdata;
                        4'd4: mOut  = mOut ^ wdata;
                        4'd6: mRise = wdata;
                        4'd7: mFall = wdata;
                        default: ;
                    endcase
                end
                mStat = (mStat & ~mClr) | mSet;
                for (int i = S; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = gin;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("model gpio_out", 32'(gpio_out), 32'(mOut));
            checkOutput("model gpio_dir", 32'(gpio_dir), 32'(mDir));
            checkOutput("model irq", 32'(irq), 32'(mIrq));
            checkOutput("model rd_valid", 32'(rd_valid), 32'(mRdv));
            checkOutput("model rdata", 32'(rdata), 32'(mRdata));
        end
    end

    task automatic applyStimulus(input logic w, input logic r, input logic [3:0] a,
                                 input logic [W-1:0] d);
        wr_en = w;
        rd_en = r;
        addr  = a;
        wdata = d;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 4'd0, '0);
    endtask

    initial begin
        logic [3:0] resetAddrs [6];
        resetAddrs = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd7, 4'd8};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cmpEn = 1'b1;

        checkOutput("reset gpio_dir", 32'(gpio_dir), 32'h0);
        checkOutput("reset irq", 32'(irq), 32'h0);
        foreach (resetAddrs[i]) begin
            applyStimulus(1'b0, 1'b1, resetAddrs[i], '0);
            checkOutput("reset rd_valid", 32'(rd_valid), 32'h1);
            checkOutput("reset rdata", 32'(rdata), 32'h0);
        end
        idle(1);
        checkOutput("rd_valid drops", 32'(rd_valid), 32'h0);

        // Back-to-back atomic updates must chain on the freshly written OUT.
        applyStimulus(1'b1, 1'b0, 4'd0, 16'hFFFF);
        checkOutput("dir all out", 32'(gpio_dir), 32'hFFFF);
        applyStimulus(1'b1, 1'b0, 4'd1, 16'h00F0);
        checkOutput("out write", 32'(gpio_out), 32'h00F0);
        applyStimulus(1'b1, 1'b0, 4'd2, 16'h000F);
        checkOutput("out set", 32'(gpio_out), 32'h00FF);
        applyStimulus(1'b1, 1'b0, 4'd3, 16'h0030);
        checkOutput("out clr", 32'(gpio_out), 32'h00CF);
        applyStimulus(1'b1, 1'b0, 4'd4, 16'hFF00);
        checkOutput("out tgl", 32'(gpio_out), 32'hFFCF);
        applyStimulus(1'b0, 1'b1, 4'd2, '0);
        checkOutput("read wo addr", 32'(rdata), 32'h0);

        applyStimulus(1'b1, 1'b0, 4'd0, 16'h0000);
        applyStimulus(1'b1, 1'b0, 4'd6, 16'h0001);
        gin = 16'h0001;
        idle(3);
        checkOutput("irq before latency", 32'(irq), 32'h0);
        applyStimulus(1'b0, 1'b1, 4'd8, '0);
        checkOutput("rise status", 32'(rdata), 32'h0001);
        checkOutput("rise irq", 32'(irq), 32'h1);
        applyStimulus(1'b0, 1'b1, 4'd5, '0);
        checkOutput("in read", 32'(rdata), 32'h0001);
        gin = 16'h0003;
        idle(4);
        applyStimulus(1'b0, 1'b1, 4'd8, '0);
        checkOutput("rise disabled pin", 32'(rdata), 32'h0001);

        applyStimulus(1'b1, 1'b0, 4'd8, 16'hFFFF);
        applyStimulus(1'b1, 1'b0, 4'd7, 16'h0006);
        applyStimulus(1'b1, 1'b0, 4'd0, 16'h0004);
        gin = 16'h0007;
        idle(4);
        applyStimulus(1'b1, 1'b0, 4'd8, 16'hFFFF);
        gin = 16'h0001;
        idle(4);
        applyStimulus(1'b0, 1'b1, 4'd8, '0);
        checkOutput("fall masked", 32'(rdata), 32'h0002);

        applyStimulus(1'b1, 1'b0, 4'd8, 16'hFFFF);
        idle(2);
        checkOutput("irq cleared", 32'(irq), 32'h0);
        gin = 16'h0000;
        idle(4);
        gin = 16'h0001;
        idle(4);
        gin = 16'h0000;
        idle(4);
        // The clear lands on the same edge the new rising edge sets the bit.
        gin = 16'h0001;
        idle(2);
        applyStimulus(1'b1, 1'b0, 4'd8, 16'h0001);
        applyStimulus(1'b0, 1'b1, 4'd8, '0);
        checkOutput("w1c collision status", 32'(rdata), 32'h0001);
        checkOutput("w1c collision irq", 32'(irq), 32'h1);
        applyStimulus(1'b1, 1'b0, 4'd8, 16'h0001);
        applyStimulus(1'b0, 1'b1, 4'd8, '0);
        checkOutput("w1c clear status", 32'(rdata), 32'h0);
        checkOutput("w1c clear irq", 32'(irq), 32'h0);

        applyStimulus(1'b1, 1'b0, 4'd1, 16'h1234);
        applyStimulus(1'b1, 1'b1, 4'd1, 16'hABCD);
        checkOutput("rw same addr rdata", 32'(rdata), 32'h1234);
        checkOutput("rw same addr out", 32'(gpio_out), 32'hABCD);

        applyStimulus(1'b1, 1'b0, 4'd0, 16'h00FF);
        rd_en = 1'b1;
        addr  = 4'd1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        rd_en = 1'b0;
        checkOutput("midreset rd_valid", 32'(rd_valid), 32'h0);
        checkOutput("midreset rdata", 32'(rdata), 32'h0);
        checkOutput("midreset gpio_out", 32'(gpio_out), 32'h0);
        checkOutput("midreset gpio_dir", 32'(gpio_dir), 32'h0);
        checkOutput("midreset irq", 32'(irq), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        applyStimulus(1'b1, 1'b0, 4'd6, 16'hFFFF);
        applyStimulus(1'b1, 1'b0, 4'd7, 16'h5A5A);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) gin = gin ^ W'($urandom & $urandom);
            applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)),
                          4'($urandom_range(15)), W'($urandom));
        end

        cmpEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/gpio_port_ctrl.md
Name: gpio_port_ctrl

Overview:
- Parametrised successor of the fixed 16-bit gpio_dir register.
- Adds a full GPIO port: direction, output data with atomic set/clear/toggle writes, synchronised input sampling, and per-pin edge-detect interrupts with W1C status.
- Sits between the peripheral register bus and the pad ring; one instance per GPIO bank.

Parameters:
- WIDTH, 16, number of GPIO pins in the bank (1..32).
- SYNC_STAGES, 2, flip-flop stages on each gpio_in bit before use (>=2).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  register write strobe, single cycle
- rd_en  in  1  register read strobe, single cycle
- addr  in  4  register index
- wdata  in  WIDTH  write data
- rdata  out  WIDTH  registered read data
- rd_valid  out  1  pulses high one cycle after rd_en
- gpio_in  in  WIDTH  asynchronous pad inputs
- gpio_out  out  WIDTH  output data to pads
- gpio_dir  out  WIDTH  per-pin direction, 1 = output, 0 = input
- irq  out  1  registered interrupt request, level

Behaviour:
- Reset: reset low forces every register, sync flop, rdata, rd_valid, gpio_out, gpio_dir and irq to 0 immediately. All pins are inputs after reset.
- Register map (addr; access):
  - 0 DIR; RW
  - 1 OUT; RW
  - 2 OUT_SET; WO, OUT |= wdata
  - 3 OUT_CLR; WO, OUT &= ~wdata
  - 4 OUT_TGL; WO, OUT ^= wdata
  - 5 IN; RO, synchronised input value
  - 6 RISE_EN; RW
  - 7 FALL_EN; RW
  - 8 STATUS; RW1C
  - 9-15: reserved; writes ignored, reads return 0
  - Reads of write-only addresses 2-4 return 0.
- Write timing: registers update at the clk edge where wr_en=1. gpio_out and gpio_dir are direct register outputs, so a change is visible the cycle after the write.
- Read timing:
  - rdata and rd_valid are valid the cycle after rd_en; rdata holds its value until the next read.
  - rd_en and wr_en together at the same addr: the read returns the pre-write value.
- Input path:
  - gpio_in passes through SYNC_STAGES flops to form sync_in; a further flop holds prev_in.
  - rise = sync_in & ~prev_in; fall = ~sync_in & prev_in.
- Status set condition: STATUS[i] is set when ~DIR[i] & ((rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i])). Edges on output pins are never flagged.
- Status latency: a gpio_in transition held stable sets STATUS SYNC_STAGES+1 cycles later; irq rises one cycle after that.
- Status clear and collisions:
  - A STATUS write clears bits where wdata=1.
  - A set and a clear of the same bit in the same cycle: set wins.
  - Disabling RISE_EN or FALL_EN does not clear already-set STATUS bits.
- irq: registered OR-reduce of STATUS. It stays high until all bits are cleared.
- OUT_SET/CLR/TGL use the current OUT value. Consecutive-cycle writes chain correctly with no lost updates.
- Reset asserted mid-operation: all state is cleared at once, and any pending rd_valid is dropped.
- Pins narrower than the bus: write bits above WIDTH are ignored; read bits above WIDTH return 0.

Test Plan:
- Reset/defaults: hold reset low, release, read addrs 0,1,5,6,7,8 -> all rdata 0x0000, rd_valid one cycle after each rd_en, gpio_dir=0, irq=0.
- Atomic output ops:
  - Sequence: write DIR=0xFFFF, OUT=0x00F0, OUT_SET=0x000F, OUT_CLR=0x0030, OUT_TGL=0xFF00 on back-to-back cycles.
  - Required: gpio_out steps 0x00F0, 0x00FF, 0x00CF, then 0xFFCF.
  - Required: a read of addr 2 returns 0.
- Input sync and edges:
  - Setup: DIR=0, RISE_EN=0x0001; drive gpio_in[0] 0->1 at cycle T.
  - Required: IN reads 0x0001 from cycle T+2; STATUS[0]=1 at T+3; irq=1 at T+4.
  - Required: gpio_in[1] rising with RISE_EN[1]=0 leaves STATUS[1]=0.
- Falling and output masking:
  - Setup: FALL_EN=0x0006, DIR=0x0004; drive gpio_in[2:1] 11->00.
  - Required: STATUS=0x0002 only, since bit 2 is an output.
- W1C collision: with STATUS[0]=1, write STATUS=0x0001 in the same cycle a new rising edge on pin 0 sets it -> STATUS[0] stays 1 and irq stays 1. A later write of 0x0001 with no edge -> STATUS=0, irq=0 the next cycle.
- Read/write same addr and reset mid-op:
  - Same-cycle rd_en+wr_en to OUT (old 0x1234, new 0xABCD) -> rdata=0x1234; OUT=0xABCD afterwards.
  - Assert reset with rd_en pending -> rd_valid=0, all outputs 0 immediately.
